// File: rtl/stack_pkg.sv
// Shared types for the LIFO RAM controller: FSM states, sticky-flag indices, SP width.
// Optional peek path is enabled by defining STACK_PEEK_EN.
package stack_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2
    } state_t;

    localparam int unsigned FLAG_OVF  = 0;
    localparam int unsigned FLAG_UDF  = 1;
    localparam int unsigned FLAG_CFL  = 2;
    localparam int unsigned NUM_FLAGS = 3;

    // SP must represent 0..DEPTH inclusive, hence one bit beyond log2(DEPTH).
    function automatic int unsigned sp_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/stack_ptr.sv
// Up/down stack-pointer counter; reports fill level and full/empty status.
// Part of stack_ctrl (optional peek path via STACK_PEEK_EN lives in the top).
module stack_ptr
    import stack_pkg::*;
#(
    parameter int unsigned DEPTH = 256
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_inc,
    input  logic                        i_dec,
    output logic [sp_width(DEPTH)-1:0]  o_level,
    output logic                        o_full,
    output logic                        o_empty
);

    localparam int unsigned SPW = sp_width(DEPTH);

    logic [SPW-1:0] r_sp;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sp <= '0;
        end else if (i_inc) begin
            r_sp <= r_sp + SPW'(1);
        end else if (i_dec) begin
            r_sp <= r_sp - SPW'(1);
        end
    end

    assign o_level = r_sp;
    assign o_full  = (r_sp == SPW'(DEPTH));
    assign o_empty = (r_sp == '0);

endmodule

// File: rtl/stack_ctrl.sv
// LIFO controller for a single-port falling-edge RAM: push/pop become 1-cycle RAM ops.
// Define STACK_PEEK_EN to add the peek input (read top of stack without popping).
module stack_ctrl
    import stack_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 8,
    parameter int unsigned           ADDR_WIDTH = 16,
    parameter int unsigned           DEPTH      = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE       = 16'hFF00
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic                        pop,
`ifdef STACK_PEEK_EN
    input  logic                        peek,
`endif
    input  logic [DATA_WIDTH-1:0]       din,
    input  logic                        clr_err,
    output logic [DATA_WIDTH-1:0]       dout,
    output logic                        dout_valid,
    output logic                        busy,
    output logic                        full,
    output logic                        empty,
    output logic [sp_width(DEPTH)-1:0]  level,
    output logic                        ovf,
    output logic                        udf,
    output logic                        cfl,
    output logic [ADDR_WIDTH-1:0]       ram_addr,
    output logic [DATA_WIDTH-1:0]       ram_din,
    output logic                        ram_we,
    input  logic [DATA_WIDTH-1:0]       ram_dout
);

    localparam int unsigned SPW = sp_width(DEPTH);

    state_t                  r_state;
    logic [DATA_WIDTH-1:0]   r_dout;
    logic                    r_dout_valid;
    logic [NUM_FLAGS-1:0]    r_flags;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic                    r_we;

    logic [SPW-1:0]          w_level;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_idle;
    logic                    w_do_pop;
    logic                    w_do_push;
    logic                    w_do_peek;
    logic                    w_peek_udf;
    logic                    w_sp_inc;
    logic [NUM_FLAGS-1:0]    w_new_err;
    logic [ADDR_WIDTH-1:0]   w_addr_top;
    logic [ADDR_WIDTH-1:0]   w_addr_below;

    stack_ptr #(
        .DEPTH (DEPTH)
    ) u_ptr (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_inc   (w_sp_inc),
        .i_dec   (w_do_pop),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_idle    = (r_state == ST_IDLE);
    assign w_do_pop  = w_idle & pop & ~w_empty;
    assign w_do_push = w_idle & push & ~pop & ~w_full;
    // SP advances only as WR retires, so an interrupted write never becomes stack content.
    assign w_sp_inc  = (r_state == ST_WR);

`ifdef STACK_PEEK_EN
    assign w_do_peek  = w_idle & peek & ~push & ~pop & ~w_empty;
    assign w_peek_udf = w_idle & peek & ~push & ~pop & w_empty;
`else
    assign w_do_peek  = 1'b0;
    assign w_peek_udf = 1'b0;
`endif

    always_comb begin
        w_new_err           = '0;
        w_new_err[FLAG_OVF] = w_idle & push & ~pop & w_full;
        w_new_err[FLAG_UDF] = (w_idle & pop & w_empty) | w_peek_udf;
        w_new_err[FLAG_CFL] = w_idle & push & pop;
    end

    assign w_addr_top   = BASE + ADDR_WIDTH'(w_level);
    assign w_addr_below = BASE + ADDR_WIDTH'(w_level - SPW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_flags      <= '0;
            r_addr       <= BASE;
            r_wdata      <= '0;
            r_we         <= 1'b1;
        end else begin
            r_dout_valid <= 1'b0;
            r_flags      <= (r_flags & ~{NUM_FLAGS{clr_err}}) | w_new_err;
            case (r_state)
                ST_IDLE: begin
                    // Pop and peek both read the entry just below the current SP.
                    if (w_do_pop || w_do_peek) begin
                        r_state <= ST_RD;
                        r_addr  <= w_addr_below;
                    end else if (w_do_push) begin
                        r_state <= ST_WR;
                        r_addr  <= w_addr_top;
                        r_wdata <= din;
                        r_we    <= 1'b0;
                    end
                end
                ST_WR: begin
                    r_we    <= 1'b1;
                    r_state <= ST_IDLE;
                end
                ST_RD: begin
                    r_dout       <= ram_dout;
                    r_dout_valid <= 1'b1;
                    r_state      <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign busy       = ~w_idle;
    assign full       = w_full;
    assign empty      = w_empty;
    assign level      = w_level;
    assign ovf        = r_flags[FLAG_OVF];
    assign udf        = r_flags[FLAG_UDF];
    assign cfl        = r_flags[FLAG_CFL];
    assign ram_addr   = r_addr;
    assign ram_din    = r_wdata;
    assign ram_we     = r_we;

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl (DEPTH=4, BASE=0x0010) with a falling-edge RAM model and a
// queue-based reference model; peek tests are included when STACK_PEEK_EN is defined.
module tb_stack_ctrl;

    localparam int          DEPTH = 4;
    localparam logic [15:0] BASE  = 16'h0010;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        push = 1'b0, pop = 1'b0, peek = 1'b0, clr_err = 1'b0;
    logic [7:0]  din = '0;
    logic [7:0]  dout;
    logic        dout_valid, busy, full, empty, ovf, udf, cfl;
    logic [2:0]  level;
    logic [15:0] ram_addr;
    logic [7:0]  ram_din, ram_dout;
    logic        ram_we;

    logic [7:0]  mem [0:65535];

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    // Reference model: a queue holds the stack, m_ph tracks the op in flight.
    logic [7:0]  stk[$];
    int          m_ph;
    logic [7:0]  m_wd, m_rd, m_dout;
    logic        m_dv, m_ovf, m_udf, m_cfl;
    logic [15:0] m_addr;

    always #5 clk = ~clk;

    stack_ctrl #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (16),
        .DEPTH      (DEPTH),
        .BASE       (BASE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .pop        (pop),
`ifdef STACK_PEEK_EN
        .peek       (peek),
`endif
        .din        (din),
        .clr_err    (clr_err),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .full       (full),
        .empty      (empty),
        .level      (level),
        .ovf        (ovf),
        .udf        (udf),
        .cfl        (cfl),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_we     (ram_we),
        .ram_dout   (ram_dout)
    );

    always @(negedge clk) begin
        if (!ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        stk.delete();
        m_ph   = 0;
        m_dout = '0;
        m_dv   = 1'b0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        m_cfl  = 1'b0;
    endfunction

    function automatic void model_step(input logic p, input logic q, input logic k,
                                       input logic [7:0] d, input logic c);
        logic eo, eu, ec;
        eo = 1'b0; eu = 1'b0; ec = 1'b0;
        m_dv = 1'b0;
        case (m_ph)
            0: begin
                if (q) begin
                    ec = p;
                    if (stk.size() == 0) eu = 1'b1;
                    else begin
                        m_rd   = stk.pop_back();
                        m_addr = BASE + 16'(stk.size());
                        m_ph   = 2;
                    end
                end else if (p) begin
                    if (stk.size() == DEPTH) eo = 1'b1;
                    else begin
                        m_wd   = d;
                        m_addr = BASE + 16'(stk.size());
                        m_ph   = 1;
                    end
                end else if (k) begin
                    if (stk.size() == 0) eu = 1'b1;
                    else begin
                        m_rd   = stk[$];
                        m_addr = BASE + 16'(stk.size() - 1);
                        m_ph   = 2;
                    end
                end
            end
            1: begin
                stk.push_back(m_wd);
                m_ph = 0;
            end
            default: begin
                m_dout = m_rd;
                m_dv   = 1'b1;
                m_ph   = 0;
            end
        endcase
        m_ovf = (m_ovf & ~c) | eo;
        m_udf = (m_udf & ~c) | eu;
        m_cfl = (m_cfl & ~c) | ec;
    endfunction

    task automatic step(input logic p, input logic q, input logic k,
                        input logic [7:0] d, input logic c);
        push = p; pop = q; peek = k; din = d; clr_err = c;
        @(posedge clk);
        model_step(p, q, k, d, c);
        #1;
        push = 1'b0; pop = 1'b0; peek = 1'b0; clr_err = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("busy",       32'(busy),       32'(m_ph != 0));
            chk("level",      32'(level),      32'(stk.size()));
            chk("full",       32'(full),       32'(stk.size() == DEPTH));
            chk("empty",      32'(empty),      32'(stk.size() == 0));
            chk("flags",      {29'd0, ovf, udf, cfl}, {29'd0, m_ovf, m_udf, m_cfl});
            chk("dout_valid", 32'(dout_valid), 32'(m_dv));
            chk("dout",       32'(dout),       32'(m_dout));
            chk("ram_we",     32'(ram_we),     32'(m_ph != 1));
            if (m_ph != 0) chk("ram_addr", 32'(ram_addr), 32'(m_addr));
            if (m_ph == 1) chk("ram_din",  32'(ram_din),  32'(m_wd));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        do_reset();
        chk_on = 1'b1;

        chk("rst_level", 32'(level),    32'd0);
        chk("rst_empty", 32'(empty),    32'd1);
        chk("rst_we",    32'(ram_we),   32'd1);
        chk("rst_addr",  32'(ram_addr), 32'h0010);

        // Fill to capacity.
        step(1'b1, 1'b0, 1'b0, 8'hA1, 1'b0); idle(1);
        step(1'b1, 1'b0, 1'b0, 8'hA2, 1'b0); idle(1);
        step(1'b1, 1'b0, 1'b0, 8'hA3, 1'b0); idle(1);
        step(1'b1, 1'b0, 1'b0, 8'hA4, 1'b0); idle(1);
        chk("fill_level", 32'(level), 32'd4);
        chk("fill_full",  32'(full),  32'd1);
        chk("ram10", 32'(mem[16'h0010]), 32'hA1);
        chk("ram11", 32'(mem[16'h0011]), 32'hA2);
        chk("ram12", 32'(mem[16'h0012]), 32'hA3);
        chk("ram13", 32'(mem[16'h0013]), 32'hA4);

        // Overflow.
        step(1'b1, 1'b0, 1'b0, 8'hFF, 1'b0); idle(1);
        chk("ovf_set",   32'(ovf),   32'd1);
        chk("ovf_level", 32'(level), 32'd4);
        chk("ram14",     32'(mem[16'h0014]), 32'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("ovf_clr",   32'(ovf),   32'd0);

        // Drain in LIFO order.
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0); idle(1);
        chk("pop1", {23'd0, dout_valid, dout}, {23'd0, 1'b1, 8'hA4});
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0); idle(1);
        chk("pop2", {23'd0, dout_valid, dout}, {23'd0, 1'b1, 8'hA3});
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0); idle(1);
        chk("pop3", {23'd0, dout_valid, dout}, {23'd0, 1'b1, 8'hA2});
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0); idle(1);
        chk("pop4", {23'd0, dout_valid, dout}, {23'd0, 1'b1, 8'hA1});
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_level", 32'(level), 32'd0);

        // Underflow, and a new error beating a simultaneous clear.
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("udf_set", 32'(udf), 32'd1);
        idle(1);
        chk("udf_nodv", 32'(dout_valid), 32'd0);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        chk("udf_clr_race", 32'(udf), 32'd1);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("udf_clr", 32'(udf), 32'd0);

        // Push+pop conflict with two entries stored.
        step(1'b1, 1'b0, 1'b0, 8'h11, 1'b0); idle(1);
        step(1'b1, 1'b0, 1'b0, 8'h22, 1'b0); idle(1);
        step(1'b1, 1'b1, 1'b0, 8'h33, 1'b0); idle(1);
        chk("cfl_set",   32'(cfl),   32'd1);
        chk("cfl_level", 32'(level), 32'd1);
        chk("cfl_dout",  {23'd0, dout_valid, dout}, {23'd0, 1'b1, 8'h22});

        // Reset in the middle of a write.
        step(1'b1, 1'b0, 1'b0, 8'h55, 1'b0);
        chk("wr_we_low", 32'(ram_we), 32'd0);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_we_async", 32'(ram_we), 32'd1);
        chk("rst_mid_level", 32'(level), 32'd0);
        chk("rst_mid_flags", {29'd0, ovf, udf, cfl}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("post_rst_udf", 32'(udf), 32'd1);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

`ifdef STACK_PEEK_EN
        step(1'b1, 1'b0, 1'b0, 8'h3C, 1'b0); idle(1);
        step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0); idle(1);
        chk("peek_dout",  {23'd0, dout_valid, dout}, {23'd0, 1'b1, 8'h3C});
        chk("peek_level", 32'(level), 32'd1);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0); idle(1);
        chk("peek_pop",   {23'd0, dout_valid, dout}, {23'd0, 1'b1, 8'h3C});
        chk("peek_empty", 32'(level), 32'd0);
`endif

        // Randomised traffic, including requests while busy.
        for (int i = 0; i < 800; i++) begin
            logic p, q, k, c;
            p = ($urandom_range(0, 99) < 50);
            q = ($urandom_range(0, 99) < 35);
            c = ($urandom_range(0, 99) < 8);
`ifdef STACK_PEEK_EN
            k = ($urandom_range(0, 99) < 20);
`else
            k = 1'b0;
`endif
            step(p, q, k, 8'($urandom), c);
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
